// File: rtl/vector_list_player_if.sv
// Host-write, playback-control and line-drawer command signals of vector_list_player.
// The player takes the slave modport; the host/drawer side takes master.
interface vector_list_player_if #(
  parameter int ADDR_W  = 8,
  parameter int COORD_W = 12
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [2+2*COORD_W-1:0]   wr_data;
  logic                     start;
  logic                     loop;
  logic                     cmd_ready;
  logic [COORD_W-1:0]       cmd_x;
  logic [COORD_W-1:0]       cmd_y;
  logic                     cmd_jump;
  logic                     cmd_draw;
  logic                     busy;
  logic                     frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, start, loop, cmd_ready,
    input  cmd_x, cmd_y, cmd_jump, cmd_draw, busy, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, loop, cmd_ready,
    output cmd_x, cmd_y, cmd_jump, cmd_draw, busy, frame_done
  );
endinterface

// File: rtl/vector_list_player.sv
// Display-list sequencer: walks a host-written RAM of END/JUMP/DRAW/NOP entries
// and hands each JUMP/DRAW to the line drawer as a registered one-cycle pulse.
module vector_list_player #(
  parameter int ADDR_W  = 8,
  parameter int COORD_W = 12
) (
  input logic                 clk,
  input logic                 reset,
  vector_list_player_if.slave bus
);
  localparam int DATA_W = 2 + 2 * COORD_W;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] DECODE   = 3'd2;
  localparam logic [2:0] WAIT_RDY = 3'd3;
  localparam logic [2:0] ISSUE    = 3'd4;
  localparam logic [2:0] SETTLE   = 3'd5;

  localparam logic [1:0] OP_END  = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [DATA_W-1:0]  mem [2**ADDR_W];
  logic [DATA_W-1:0]  rd_q;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, addr_inc;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d;
  logic               draw_sel_q, draw_sel_d;
  logic               wrap_q, wrap_d;
  logic               jump_q, jump_d, draw_q, draw_d;
  logic               busy_q, busy_d, frame_q, frame_d;

  logic [1:0]         rd_op;
  logic [COORD_W-1:0] rd_x, rd_y;

  assign rd_op    = rd_q[DATA_W-1 -: 2];
  assign rd_x     = rd_q[2*COORD_W-1 -: COORD_W];
  assign rd_y     = rd_q[COORD_W-1:0];
  assign addr_inc = addr_q + ADDR_W'(1);

  // Read-first list RAM; the read port follows addr_q every cycle, so the
  // word addressed during FETCH is what DECODE sees.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    rd_q <= mem[addr_q];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    draw_sel_d = draw_sel_q;
    wrap_d     = wrap_q;
    cmd_x_d    = cmd_x_q;
    cmd_y_d    = cmd_y_q;
    jump_d     = 1'b0;
    draw_d     = 1'b0;
    frame_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        case (rd_op)
          OP_END: begin
            frame_d = 1'b1;
            addr_d  = '0;
            state_d = bus.loop ? FETCH : IDLE;
          end
          OP_NOP: begin
            addr_d = addr_inc;
            if (addr_q == LAST_ADDR) begin
              frame_d = 1'b1;
              state_d = bus.loop ? FETCH : IDLE;
            end else begin
              state_d = FETCH;
            end
          end
          default: begin
            x_d        = rd_x;
            y_d        = rd_y;
            draw_sel_d = (rd_op == OP_DRAW);
            state_d    = WAIT_RDY;
          end
        endcase
      end
      WAIT_RDY: begin
        if (bus.cmd_ready) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_x_d = x_q;
        cmd_y_d = y_q;
        jump_d  = ~draw_sel_q;
        draw_d  = draw_sel_q;
        addr_d  = addr_inc;
        wrap_d  = (addr_q == LAST_ADDR);
        state_d = SETTLE;
      end
      SETTLE: begin
        // A wrap on a command is reported here so frame_done never lands on a pulse.
        if (wrap_q) begin
          wrap_d  = 1'b0;
          frame_d = 1'b1;
          state_d = bus.loop ? FETCH : IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      draw_sel_q <= 1'b0;
      wrap_q     <= 1'b0;
      cmd_x_q    <= '0;
      cmd_y_q    <= '0;
      jump_q     <= 1'b0;
      draw_q     <= 1'b0;
      busy_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      draw_sel_q <= draw_sel_d;
      wrap_q     <= wrap_d;
      cmd_x_q    <= cmd_x_d;
      cmd_y_q    <= cmd_y_d;
      jump_q     <= jump_d;
      draw_q     <= draw_d;
      busy_q     <= busy_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.cmd_x      = cmd_x_q;
  assign bus.cmd_y      = cmd_y_q;
  assign bus.cmd_jump   = jump_q;
  assign bus.cmd_draw   = draw_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_vector_list_player.sv
// Bench for vector_list_player: per-cycle comparison against an event-timeline
// model of the list walk, plus directed ready-stall and mid-pass reset cases.
module tb_vector_list_player;
  localparam int AW    = 3;
  localparam int CW    = 12;
  localparam int DEPTH = 8;
  localparam int MAXC  = 160;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vector_list_player_if #(.ADDR_W(AW), .COORD_W(CW)) bus ();
  vector_list_player #(.ADDR_W(AW), .COORD_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]    op;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } entry_t;

  entry_t        lst [DEPTH];
  bit            eJ [MAXC];
  bit            eD [MAXC];
  bit            eF [MAXC];
  logic [CW-1:0] eX [MAXC];
  logic [CW-1:0] eY [MAXC];
  int            endT;
  logic [CW-1:0] mX, mY;
  int            vectors, miscompares;

  task automatic checkOutput(input string tag, input int k, input logic [31:0] obs,
                             input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s @%0d: observed %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  // Timeline from the list costs: command = 5 cycles with its pulse 4 edges in,
  // NOP/END = 2 cycles, running off the last address ends the pass.
  task automatic buildModel(input int passes);
    int t, a, p;
    bit done;
    for (int k = 0; k < MAXC; k++) begin
      eJ[k] = 0; eD[k] = 0; eF[k] = 0; eX[k] = '0; eY[k] = '0;
    end
    t = 0; a = 0; p = 0; done = 0;
    while (!done) begin
      if (lst[a].op == 2'b00) begin
        t += 2; eF[t] = 1; p++; a = 0; done = (p == passes);
      end else begin
        if (lst[a].op == 2'b11) begin
          t += 2;
        end else begin
          if (lst[a].op == 2'b01) eJ[t+4] = 1; else eD[t+4] = 1;
          eX[t+4] = lst[a].x; eY[t+4] = lst[a].y;
          t += 5;
        end
        if (a == DEPTH - 1) begin
          eF[t] = 1; p++; a = 0; done = (p == passes);
        end else begin
          a++;
        end
      end
    end
    endT = t;
  endtask

  task automatic loadList();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a[AW-1:0];
      bus.wr_data = {lst[a].op, lst[a].x, lst[a].y};
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int passes, input int abortAt);
    int frames;
    buildModel(passes);
    frames = 0;
    @(negedge clk);
    bus.loop = (passes > 1); bus.cmd_ready = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k <= endT + 2; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (eJ[k] || eD[k]) begin
        mX = eX[k]; mY = eY[k];
      end
      checkOutput("cmd_jump",   k, 32'(bus.cmd_jump),   32'(eJ[k]));
      checkOutput("cmd_draw",   k, 32'(bus.cmd_draw),   32'(eD[k]));
      checkOutput("frame_done", k, 32'(bus.frame_done), 32'(eF[k]));
      checkOutput("busy",       k, 32'(bus.busy),       (k < endT) ? 32'd1 : 32'd0);
      checkOutput("cmd_x",      k, 32'(bus.cmd_x),      32'(mX));
      checkOutput("cmd_y",      k, 32'(bus.cmd_y),      32'(mY));
      if (k == abortAt) break;
      frames += int'(eF[k]);
      bus.loop = (frames < passes - 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.loop = 1'b0; bus.cmd_ready = 1'b1;
    mX = '0; mY = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_jump",  0, 32'(bus.cmd_jump),   32'd0);
    checkOutput("rst_draw",  0, 32'(bus.cmd_draw),   32'd0);
    checkOutput("rst_frame", 0, 32'(bus.frame_done), 32'd0);
    checkOutput("rst_busy",  0, 32'(bus.busy),       32'd0);
    checkOutput("rst_x",     0, 32'(bus.cmd_x),      32'd0);
    checkOutput("rst_y",     0, 32'(bus.cmd_y),      32'd0);
    reset = 1'b1;

    // Square pattern, single pass then three looped passes.
    for (int a = 0; a < DEPTH; a++) begin
      lst[a].op = 2'b11; lst[a].x = 12'($urandom); lst[a].y = 12'($urandom);
    end
    lst[0] = '{2'b01, 12'd50, 12'd10};
    lst[1] = '{2'b10, 12'd0,  12'd40};
    lst[2] = '{2'b10, 12'd50, 12'd50};
    lst[3] = '{2'b10, 12'd0,  12'd0};
    lst[4] = '{2'b00, 12'd0,  12'd0};
    loadList();
    applyStimulus(1, -1);
    applyStimulus(3, -1);

    // Leading NOPs delay the single draw.
    lst[0].op = 2'b11; lst[1].op = 2'b11; lst[2].op = 2'b11;
    lst[3] = '{2'b10, 12'd7, 12'd9};
    lst[4].op = 2'b00;
    loadList();
    applyStimulus(1, -1);

    // No END: the pass ends by wrapping past the last address.
    for (int a = 0; a < DEPTH; a++) begin
      lst[a] = '{2'b10, 12'($urandom), 12'($urandom)};
    end
    loadList();
    applyStimulus(1, -1);

    repeat (6) begin
      for (int a = 0; a < DEPTH; a++) begin
        lst[a].op = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        lst[a].x  = 12'($urandom);
        lst[a].y  = 12'($urandom);
      end
      loadList();
      applyStimulus(int'($urandom_range(1, 3)), -1);
    end

    // Drawer not ready: the command waits, then issues exactly once.
    lst[0] = '{2'b10, 12'($urandom), 12'($urandom)};
    lst[1].op = 2'b00;
    loadList();
    @(negedge clk);
    bus.loop = 1'b0; bus.cmd_ready = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      checkOutput("stall_jump", k, 32'(bus.cmd_jump), 32'd0);
      checkOutput("stall_draw", k, 32'(bus.cmd_draw), 32'd0);
      checkOutput("stall_x",    k, 32'(bus.cmd_x),    32'(mX));
      checkOutput("stall_y",    k, 32'(bus.cmd_y),    32'(mY));
      checkOutput("stall_busy", k, 32'(bus.busy),     32'd1);
    end
    bus.cmd_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("ready_issue_draw", 23, 32'(bus.cmd_draw), 32'd0);
    @(posedge clk); @(negedge clk);
    mX = lst[0].x; mY = lst[0].y;
    bus.cmd_ready = 1'b0;
    checkOutput("ready_pulse_draw", 24, 32'(bus.cmd_draw), 32'd1);
    checkOutput("ready_pulse_x",    24, 32'(bus.cmd_x),    32'(mX));
    checkOutput("ready_pulse_y",    24, 32'(bus.cmd_y),    32'(mY));
    @(posedge clk); @(negedge clk);
    checkOutput("ready_after_draw", 25, 32'(bus.cmd_draw), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("ready_frame_early", 26, 32'(bus.frame_done), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("ready_frame", 27, 32'(bus.frame_done), 32'd1);
    checkOutput("ready_busy",  27, 32'(bus.busy),       32'd0);

    // Reset while the first command of the second pass waits for ready.
    for (int a = 0; a < DEPTH; a++) begin
      lst[a] = '{2'($urandom_range(1, 2)), 12'($urandom), 12'($urandom)};
    end
    loadList();
    applyStimulus(2, 42);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("mid_rst_jump",  0, 32'(bus.cmd_jump),   32'd0);
    checkOutput("mid_rst_draw",  0, 32'(bus.cmd_draw),   32'd0);
    checkOutput("mid_rst_frame", 0, 32'(bus.frame_done), 32'd0);
    checkOutput("mid_rst_busy",  0, 32'(bus.busy),       32'd0);
    checkOutput("mid_rst_x",     0, 32'(bus.cmd_x),      32'd0);
    checkOutput("mid_rst_y",     0, 32'(bus.cmd_y),      32'd0);
    reset = 1'b1;
    mX = '0; mY = '0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); @(negedge clk);
      checkOutput("post_rst_busy", k, 32'(bus.busy),     32'd0);
      checkOutput("post_rst_jump", k, 32'(bus.cmd_jump), 32'd0);
      checkOutput("post_rst_draw", k, 32'(bus.cmd_draw), 32'd0);
    end
    applyStimulus(1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vector_list_player.md
# vector_list_player

Display-list sequencer sitting directly upstream of the line-draw control stage. Holds a host-writable list of vector commands in an internal RAM, walks the list per frame, and issues each JUMP/DRAW to the line drawer as a target coordinate plus a one-cycle `cmd_jump`/`cmd_draw` pulse, gated by the drawer's `cmd_ready`. Replaces ad-hoc test-pattern generation with a fully synchronous, clk-domain handshake.

## Interface
- `ADDR_W`, 8: list address width; list depth = 2^ADDR_W entries.
- `COORD_W`, 12: coordinate width for X and Y.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  host write strobe into list RAM.
- `wr_addr`  in  ADDR_W  host write address.
- `wr_data`  in  2+2*COORD_W  entry: [op(2) | x(COORD_W) | y(COORD_W)], op in MSBs.
- `start`  in  1  begin playback at address 0 (sampled in IDLE only).
- `loop`  in  1  1 = restart list after END; 0 = return to IDLE.
- `cmd_ready`  in  1  line drawer idle and able to accept a command.
- `cmd_x`, `cmd_y`  out  COORD_W  target coordinate to the line drawer.
- `cmd_jump`  out  1  one-cycle pulse: move beam to target, blanked.
- `cmd_draw`  out  1  one-cycle pulse: draw line to target.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at end of each list pass.

## Operation
- Opcodes: 00 END, 01 JUMP, 10 DRAW, 11 NOP (skipped, no output).
- RAM: 2^ADDR_W x (2+2*COORD_W), synchronous read, 1-cycle latency, read-first on same-address write. Writes accepted in any state; an entry rewritten during playback takes effect on its next fetch.
- FSM states: IDLE, FETCH, DECODE, WAIT_RDY, ISSUE, SETTLE.
  - IDLE: `start`=1 -> addr:=0, FETCH.
  - FETCH: present addr to RAM -> DECODE.
  - DECODE: op END -> pulse `frame_done`, addr:=0, FETCH if `loop` else IDLE; NOP -> addr+1, FETCH; JUMP/DRAW -> latch x/y/op, WAIT_RDY.
  - WAIT_RDY: `cmd_ready`=1 -> ISSUE; else stay (no timeout).
  - ISSUE: drive `cmd_x`/`cmd_y` from latch, pulse `cmd_jump` or `cmd_draw` (exactly one), addr+1 -> SETTLE.
  - SETTLE: one dead cycle, `cmd_ready` ignored -> FETCH.
- Address wrap: increment past 2^ADDR_W-1 wraps to 0 and counts as implicit END (frame_done pulse, loop/IDLE decision identical to END).
- `start` outside IDLE ignored. `loop` sampled only at END/wrap.

## Timing
- Reset (reset=0 at a rising edge): state IDLE, addr 0, `cmd_x`=`cmd_y`=0, `cmd_jump`=`cmd_draw`=0, `busy`=0, `frame_done`=0. Reset mid-command aborts immediately; no partial pulse emitted. RAM contents not cleared.
- All outputs registered. `cmd_x`/`cmd_y` change only in the cycle of a pulse and hold until the next pulse.
- `start` sampled at edge N, `cmd_ready` held 1: `busy`=1 from N+1; first pulse asserted for the cycle following edge N+4 (FETCH, DECODE, WAIT_RDY, ISSUE).
- Command throughput with `cmd_ready` held 1: 5 cycles per JUMP/DRAW; NOP costs 2 cycles; END costs 2 cycles.
- Drawer contract: `cmd_ready` must fall within 1 cycle after a pulse; SETTLE plus FETCH/DECODE guarantee ready is not re-sampled for 3 cycles after a pulse, so no double issue.
- `frame_done` and command pulses never coincide.

## Test plan
- List {JUMP(50,10), DRAW(0,40), DRAW(50,50), DRAW(0,0), END}, loop=0, cmd_ready=1 -> four pulses jump,draw,draw,draw with matching x/y, pulses 5 cycles apart, frame_done once, busy falls, IDLE.
- Same list, loop=1 -> sequence repeats; frame_done every 22 cycles; deassert loop -> stops after current pass.
- cmd_ready held 0 for 20 cycles at WAIT_RDY -> no pulse, cmd_x/cmd_y unchanged; ready rises -> pulse in following ISSUE cycle only.
- NOP at addresses 0-2 then DRAW(7,9), END -> first pulse 6 cycles later than without NOPs; single cmd_draw at (7,9).
- ADDR_W=2, four DRAWs no END, loop=0 -> four pulses, wrap pulses frame_done, IDLE; reset=0 during WAIT_RDY of second pass -> all outputs 0, IDLE next cycle, start replays from address 0.
